muldiv_sequencer: RTL and testbench

Multi-cycle signed MULT/DIV engine sequenced by the main control unit through its multControl/divControl strobes. Runs an iterative radix-2 Booth multiplier or a restoring divider over 32 iteration cycles. Results go to a HI/LO register pair read by the register-file write mux. While the engine runs, it holds busy so the control unit can stall later HI/LO consumers.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_sequencer_if.sv | 32 +++
 rtl/div_restore_step.sv | 33 +++
 rtl/muldiv_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the MULT/DIV sequencer
//
// Purpose: state encoding, default operand/counter widths and Booth pair codes
// shared by the interface, the sequencer top and the divider step.
// Ports: none (package).

package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // {Q[0], q_-1} pairs that change the accumulator; 00 and 11 only shift.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - control/result bundle between control unit and MULT/DIV engine
//
// Purpose: groups the start strobes, operands and HI/LO result signals.
// Signals: mult_start, div_start, op_a, op_b (control -> engine);
//          busy, done, hi, lo, div0_excp (engine -> control).
// Modports: master = control unit side, slave = engine side.

interface muldiv_sequencer_if #(
  parameter int WIDTH = muldiv_pkg::MD_WIDTH
);

  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0_excp;

  modport master (
    output mult_start, div_start, op_a, op_b,
    input  busy, done, hi, lo, div0_excp
  );

  modport slave (
    input  mult_start, div_start, op_a, op_b,
    output busy, done, hi, lo, div0_excp
  );

endinterface

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational iteration of an unsigned restoring divider
//
// Purpose: shifts {R,Q} left by one, tries R-D and keeps it when non-negative.
// Ports: i_r  partial remainder (always < i_d on entry)
//        i_q  dividend bits still to shift in / quotient bits so far
//        i_d  divisor magnitude
//        o_r  next partial remainder
//        o_q  next quotient register (new bit in o_q[0])

module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  assign w_sh   = {i_r, i_q[WIDTH-1]};
  assign w_ge   = (w_sh >= {1'b0, i_d});
  // The kept difference is below i_d, so WIDTH bits are enough and the
  // modular subtraction on the low bits is exact whenever it is kept.
  assign w_diff = w_sh[WIDTH-1:0] - i_d;

  assign o_r = w_ge ? w_diff : w_sh[WIDTH-1:0];
  assign o_q = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative signed Booth multiplier / restoring divider with HI/LO
//
// Purpose: accepts one-cycle mult_start/div_start strobes, iterates WIDTH cycles,
// and publishes the result on hi/lo during the single done cycle.
// Ports: clk   rising-edge clock
//        reset asynchronous active-low reset
//        bus   muldiv_sequencer_if.slave (starts, operands, busy/done, hi/lo, div0_excp)
// Optional: MULDIV_DIV0_EXCP_EN - divide by zero skips iteration and pulses div0_excp
//           with done; otherwise div0_excp is tied low and the divide runs normally.

module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  // r_acc: Booth accumulator (one guard bit) or divider partial remainder.
  // r_q:   Booth multiplier Q or divider dividend/quotient.
  // r_m:   multiplicand or divisor magnitude.
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_qm1;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_div_skip;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_acc_sum;
  logic [WIDTH:0]   w_b_acc;
  logic [WIDTH-1:0] w_b_q;
  logic [WIDTH-1:0] w_d_r;
  logic [WIDTH-1:0] w_d_q;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

`ifdef MULDIV_DIV0_EXCP_EN
  logic r_div0;
  assign w_div_skip = (bus.op_b == '0);
`else
  assign w_div_skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state; mult_start has priority over div_start in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.mult_start)     w_next = MULT;
        else if (bus.div_start) w_next = w_div_skip ? DONE : DIV;
      end
      MULT:    if (r_cnt == '0) w_next = DONE;
      DIV:     if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Booth step: add/subtract sign-extended M, then arithmetic shift {acc,Q,q_-1}.
  assign w_m_ext = {r_m[WIDTH-1], r_m};
  always_comb begin
    w_acc_sum = r_acc;
    case ({r_q[0], r_qm1})
      BOOTH_SUB: w_acc_sum = r_acc - w_m_ext;
      BOOTH_ADD: w_acc_sum = r_acc + w_m_ext;
      default:   w_acc_sum = r_acc;
    endcase
  end
  assign w_b_acc = {w_acc_sum[WIDTH], w_acc_sum[WIDTH:1]};
  assign w_b_q   = {w_acc_sum[0], r_q[WIDTH-1:1]};

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .i_r (r_acc[WIDTH-1:0]),
    .i_q (r_q),
    .i_d (r_m),
    .o_r (w_d_r),
    .o_q (w_d_q)
  );

  // The most negative operand maps to its own bit pattern, which reads
  // correctly as the unsigned magnitude.
  assign w_abs_a = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
  assign w_abs_b = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
  assign w_fix_q = (r_sa ^ r_sb) ? -r_q : r_q;
  assign w_fix_r = r_sa ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  // Datapath and HI/LO; hi/lo load only on the edge that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_qm1 <= 1'b0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mult_start) begin
            r_acc <= '0;
            r_q   <= bus.op_b;
            r_m   <= bus.op_a;
            r_qm1 <= 1'b0;
            r_cnt <= CNT_LAST;
          end else if (bus.div_start && !w_div_skip) begin
            r_acc <= '0;
            r_q   <= w_abs_a;
            r_m   <= w_abs_b;
            r_sa  <= bus.op_a[WIDTH-1];
            r_sb  <= bus.op_b[WIDTH-1];
            r_cnt <= CNT_LAST;
          end
        end
        MULT: begin
          r_acc <= w_b_acc;
          r_q   <= w_b_q;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == '0) begin
            r_hi <= w_b_acc[WIDTH-1:0];
            r_lo <= w_b_q;
          end
        end
        DIV: begin
          r_acc <= {1'b0, w_d_r};
          r_q   <= w_d_q;
          r_cnt <= r_cnt - CNT_ONE;
        end
        FIX: begin
          r_hi <= w_fix_r;
          r_lo <= w_fix_q;
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIV0_EXCP_EN
  // Remembers that the coming DONE cycle comes from a skipped divide by zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_div0 <= 1'b0;
    else if (r_state == IDLE)  r_div0 <= bus.div_start && !bus.mult_start && w_div_skip;
    else if (r_state == DONE)  r_div0 <= 1'b0;
  end
  assign bus.div0_excp = (r_state == DONE) && r_div0;
`else
  assign bus.div0_excp = 1'b0;
`endif

  assign bus.busy = (r_state == MULT) || (r_state == DIV) || (r_state == FIX);
  assign bus.done = (r_state == DONE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer

module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial forever #5 clk = ~clk;

  // Reference results straight from signed arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output int edges, output int busy_n, output bit ex);
    longint sa, sb, lq, lr;
    ex = 1'b0;
    edges = 34;
    busy_n = 33;
    if (b == 32'd0) begin
`ifdef MULDIV_DIV0_EXCP_EN
      q = exp_lo; r = exp_hi; edges = 1; busy_n = 0; ex = 1'b1;
`else
      q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
`endif
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0];
      r = lr[31:0];
    end
  endtask

  // Drives one operation and observes it; returns what the DUT showed.
  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input int poke_div_edge, input bit poke_in_done,
                        output logic [31:0] ohi, output logic [31:0] olo,
                        output int edges, output int busy_n, output bit ex,
                        output bit moved, output bit pulse_ok);
    @(negedge clk);
    bus.mult_start = m; bus.div_start = d; bus.op_a = a; bus.op_b = b;
    edges = 0; busy_n = 0; moved = 1'b0; pulse_ok = 1'b0; ex = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    while (!bus.done && edges < 200) begin
      bus.div_start = (edges == poke_div_edge - 1);
      if (bus.busy) busy_n++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) moved = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus.div_start = 1'b0;
    ohi = bus.hi; olo = bus.lo; ex = bus.div0_excp;
    if (poke_in_done) begin
      bus.mult_start = 1'b1; bus.op_a = $urandom; bus.op_b = $urandom;
    end
    @(posedge clk);
    @(negedge clk);
    bus.mult_start = 1'b0;
    pulse_ok = !bus.done && !bus.busy && !bus.div0_excp;
  endtask

  task automatic test_reset;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div0_excp !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b excp=%b required 0 0 0", bus.busy, bus.done, bus.div0_excp);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h required 0 0", bus.hi, bus.lo);
    end
  endtask

  // Directed and random multiplies share this body.
  task automatic do_mult(input string name, input bit also_div, input logic [31:0] a,
                         input logic [31:0] b, input int poke, input bit poke_done);
    logic [31:0] h, l;
    logic [63:0] p;
    int e, bn;
    bit ex, mv, pk;
    p = ref_mul(a, b);
    run_op(1'b1, also_div, a, b, poke, poke_done, h, l, e, bn, ex, mv, pk);
    checks++;
    if (h !== p[63:32] || l !== p[31:0]) begin
      errors++;
      $display("FAIL %s_result: a=%h b=%h hi=%h lo=%h required %h %h", name, a, b, h, l, p[63:32], p[31:0]);
    end
    checks++;
    if (e !== 33 || bn !== 32 || ex !== 1'b0) begin
      errors++;
      $display("FAIL %s_timing: done_edge=%0d busy=%0d excp=%b required 33 32 0", name, e, bn, ex);
    end
    checks++;
    if (mv || !pk) begin
      errors++;
      $display("FAIL %s_hold: hilo_moved=%b pulse_ok=%b required 0 1", name, mv, pk);
    end
    exp_hi = p[63:32];
    exp_lo = p[31:0];
  endtask

  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l, q, r;
    int e, bn, ee, eb;
    bit ex, eex, mv, pk;
    ref_div(a, b, q, r, ee, eb, eex);
    run_op(1'b0, 1'b1, a, b, 0, 1'b0, h, l, e, bn, ex, mv, pk);
    checks++;
    if (h !== r || l !== q) begin
      errors++;
      $display("FAIL %s_result: a=%h b=%h hi=%h lo=%h required %h %h", name, a, b, h, l, r, q);
    end
    checks++;
    if (e !== ee || bn !== eb || ex !== eex) begin
      errors++;
      $display("FAIL %s_timing: done_edge=%0d busy=%0d excp=%b required %0d %0d %b", name, e, bn, ex, ee, eb, eex);
    end
    checks++;
    if (mv || !pk) begin
      errors++;
      $display("FAIL %s_hold: hilo_moved=%b pulse_ok=%b required 0 1", name, mv, pk);
    end
    exp_hi = r;
    exp_lo = q;
  endtask

  task automatic test_directed;
    do_mult("mul_7_m3", 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0, 1'b0);
    checks++;
    if (exp_hi !== 32'hFFFF_FFFF || exp_lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mul_7_m3_model: hi=%h lo=%h required ffffffff ffffffeb", exp_hi, exp_lo);
    end
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'h0000_0002);
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("div_5_0", 32'h0000_0005, 32'h0000_0000);
    do_div("div_m5_0", 32'hFFFF_FFFB, 32'h0000_0000);
    do_div("div_min_min", 32'h8000_0000, 32'h8000_0000);
    do_mult("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    do_mult("both_starts", 1'b1, 32'd6, 32'd3, 0, 1'b0);
  endtask

  task automatic test_random_mult;
    for (int i = 0; i < 16; i++)
      do_mult("rnd_mul", 1'b0, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8, 0, 1'b0);
  endtask

  task automatic test_random_div;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) begin
      b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
      do_div("rnd_div", $urandom, b);
    end
  endtask

  // div_start during MULT and mult_start during DONE must both be ignored.
  task automatic test_ignore_starts;
    do_mult("div_in_mult", 1'b0, 32'd123456, 32'hFFFF_0001, 10, 1'b0);
    do_mult("start_in_done", 1'b0, 32'hDEAD_BEEF, 32'd77, 0, 1'b1);
    do_div("back_to_back", 32'd1000, 32'd7);
  endtask

  task automatic test_reset_abort;
    logic [31:0] h, l;
    int e, bn;
    bit ex, mv, pk, saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    bus.mult_start = 1'b1; bus.op_a = 32'h1234_5678; bus.op_b = 32'h0000_0003;
    @(posedge clk);
    e = 1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    while (e < 19) begin
      bus.div_start = (e == 9);
      if (bus.done) saw_done = 1'b1;
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    bus.div_start = 1'b0;
    reset = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done: activity_seen=%b required 0", saw_done);
    end
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 0, 1'b0, h, l, e, bn, ex, mv, pk);
    checks++;
    if (h !== 32'd0 || l !== 32'd12 || e !== 33) begin
      errors++;
      $display("FAIL abort_fresh_mul: hi=%h lo=%h edge=%0d required 0 c 33", h, l, e);
    end
    exp_hi = 32'd0;
    exp_lo = 32'd12;
  endtask

  initial begin
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random_mult();
    test_random_div();
    test_ignore_starts();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
